// File: rtl/cbb_pkg.sv
// cbb_pkg: definitions shared by the cbb_* building blocks.
//   occ_w(depth) : width of an occupancy count for 0..depth (minimum 1 bit).
package cbb_pkg;

  function automatic int unsigned occ_w(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cbb_pipe_stage.sv
// cbb_pipe_stage: one valid/data register pair of the cbb_pipe_regs pipeline.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   clr_i         : clears the valid bit only (data untouched)
//   up_valid_i/up_data_i : word offered by the previous stage (or pipeline input)
//   dn_ready_i    : ready of the next stage (or downstream out_ready)
//   ready_o       : this stage can load this cycle (empty or next stage ready)
//   valid_o/data_o: registered stage contents
module cbb_pipe_stage #(
  parameter int unsigned          WIDTH    = 8,
  parameter logic [WIDTH-1:0]     INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             dn_ready_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  assign ready_o = !v_q || dn_ready_i;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (clr_i) begin
      v_d = 1'b0;
    end else if (ready_o) begin
      v_d = up_valid_i;
      // Data only moves with a real word, so bubbles never disturb it.
      if (up_valid_i) d_d = up_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= INIT_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign valid_o = v_q;
  assign data_o  = d_q;

endmodule

// File: rtl/cbb_pipe_regs.sv
// cbb_pipe_regs: DEPTH-deep, WIDTH-wide register pipeline with per-stage
// valid/ready handshake and bubble collapsing.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid/in_data    : upstream word;  in_ready : word accepted this cycle
//   out_valid/out_data  : last stage;     out_ready: downstream accepts
//   occ                 : number of valid stages (combinational popcount)
//   flush               : only when CBB_PIPE_FLUSH_EN is defined; clears all
//                         valid bits, drops any word offered that cycle
// in_ready depends combinationally on out_ready through a DEPTH-long OR
// chain; intended for DEPTH <= 8.
module cbb_pipe_regs
  import cbb_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [occ_w(DEPTH)-1:0]   occ
`ifdef CBB_PIPE_FLUSH_EN
  ,
  input  logic                      flush
`endif
);

  localparam int unsigned OCC_W = occ_w(DEPTH);

  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic             clr;

`ifdef CBB_PIPE_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             dn_r;

    if (i == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = v[i-1];
      assign up_d = d[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign dn_r = out_ready;
    end else begin : g_mid
      assign dn_r = r[i+1];
    end

    cbb_pipe_stage #(
      .WIDTH    (WIDTH),
      .INIT_VAL (INIT_VAL)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr),
      .up_valid_i (up_v),
      .up_data_i  (up_d),
      .dn_ready_i (dn_r),
      .ready_o    (r[i]),
      .valid_o    (v[i]),
      .data_o     (d[i])
    );
  end

  assign in_ready  = r[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(v[i]);
    end
  end

endmodule

// File: tb/tb_cbb_pipe_regs.sv
module tb_cbb_pipe_regs;

  localparam int unsigned W    = 8;
  localparam int unsigned D    = 3;
  localparam logic [7:0]  INIT = 8'h5A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [1:0] occ;

  always #5 clk = ~clk;

  cbb_pipe_regs #(
    .WIDTH    (W),
    .DEPTH    (D),
    .INIT_VAL (INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occ       (occ)
`ifdef CBB_PIPE_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  // Reference model: words in arrival order, each tagged with the stage it sits in.
  typedef struct {
    logic [7:0] data;
    int         pos;
  } word_t;

  word_t      q[$];
  logic [7:0] last_d;
  bit         model_valid = 0;
  logic [7:0] emitted[$];
  int         total  = 0;
  int         passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step(input bit rs, input bit fl, input bit acc, input logic [7:0] dat,
                            input bit ordy);
    int lim;
    int np;
    if (rs) begin
      q.delete();
      last_d = INIT;
      model_valid = 1;
      return;
    end
    if (fl) begin
      q.delete();
      return;
    end
    if (q.size() > 0 && q[0].pos == D - 1 && ordy) void'(q.pop_front());
    // Each word slides one stage forward if the slot ahead is (or becomes) free.
    lim = D;
    for (int i = 0; i < q.size(); i++) begin
      np = (q[i].pos + 1 < lim - 1) ? q[i].pos + 1 : lim - 1;
      q[i].pos = np;
      lim = np;
      if (np == D - 1) last_d = q[i].data;
    end
    if (acc) q.push_back('{data: dat, pos: 0});
  endtask

  task automatic cycle(input bit rs, input bit fl, input bit iv, input logic [7:0] dat,
                       input bit ordy);
    bit exp_ir;
    bit exp_ov;
    @(negedge clk);
    rst       = rs;
    flush     = fl;
    in_valid  = iv;
    in_data   = dat;
    out_ready = ordy;
    #1;
    exp_ir = (q.size() < D) || ordy;
    exp_ov = (q.size() > 0) && (q[0].pos == D - 1);
    if (model_valid) begin
      check("in_ready",  32'(in_ready),  32'(exp_ir));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("occ",       32'(occ),       32'(q.size()));
      check("out_data",  32'(out_data),  32'(last_d));
    end
    if (out_valid && ordy) emitted.push_back(out_data);
    @(posedge clk);
    model_step(rs, fl, iv && exp_ir, dat, ordy);
  endtask

  task automatic expect_seq(input string tag, input logic [7:0] first, input int n);
    logic [7:0] e;
    check({tag, "_count"}, 32'(emitted.size()), 32'(n));
    e = first;
    for (int i = 0; i < n; i++) begin
      if (i < emitted.size()) check({tag, "_word"}, 32'(emitted[i]), 32'(e));
      e = e + 8'd1;
    end
    emitted.delete();
  endtask

  initial begin
    // Reset: two cycles, reset state is checked on the following cycle.
    cycle(1, 0, 0, 8'h00, 0);
    cycle(1, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 0);
    check("reset_out_data", 32'(out_data), 32'(INIT));
    emitted.delete();

    // Streaming 0x01..0x10 back-to-back.
    for (int i = 1; i <= 16; i++) cycle(0, 0, 1, 8'(i), 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 8'h00, 1);
    expect_seq("stream", 8'h01, 16);

    // Back-pressure fill, 0x24 held while full.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'(8'h21 + i), 0);
    cycle(0, 0, 1, 8'h24, 0);
    check("full_occ", 32'(occ), 32'(D));
    check("full_in_ready", 32'(in_ready), 32'(0));
    cycle(0, 0, 1, 8'h24, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 8'h00, 1);
    expect_seq("backpressure", 8'h21, 4);

    // Bubble collapse.
    cycle(0, 0, 1, 8'h31, 0);
    cycle(0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'h32, 0);
    cycle(0, 0, 0, 8'h00, 0);
    check("bubble_occ", 32'(occ), 32'(2));
    check("bubble_in_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1);
    expect_seq("bubble", 8'h31, 2);

    // Simultaneous accept and emit on a full pipeline.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'(8'h3D + i), 0);
    cycle(0, 0, 1, 8'h40, 1);
    cycle(0, 0, 0, 8'h00, 0);
    check("simul_occ", 32'(occ), 32'(3));
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 8'h00, 1);
    expect_seq("simul", 8'h3D, 4);

`ifdef CBB_PIPE_FLUSH_EN
    // Flush drops in-flight words and the word offered alongside it.
    cycle(0, 0, 1, 8'h50, 0);
    cycle(0, 0, 1, 8'h51, 0);
    cycle(0, 1, 1, 8'h55, 0);
    cycle(0, 0, 0, 8'h00, 0);
    check("flush_occ", 32'(occ), 32'(0));
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1);
    expect_seq("flush", 8'h00, 0);
`endif

    // Mid-stream reset.
    cycle(0, 0, 1, 8'h60, 0);
    cycle(0, 0, 1, 8'h61, 0);
    cycle(1, 0, 1, 8'h66, 0);
    cycle(0, 0, 0, 8'h00, 0);
    check("midrst_out_data", 32'(out_data), 32'(INIT));
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1);
    expect_seq("midrst", 8'h00, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit rs;
      bit fl;
      rs = ($urandom_range(0, 96) == 0);
      fl = 0;
`ifdef CBB_PIPE_FLUSH_EN
      fl = ($urandom_range(0, 60) == 0);
`endif
      cycle(rs, fl, ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
